m68k_bus_responder: RTL

//  Slave side of the 68000 bus: consumes the per-region select lines from the

---
 rtl/toaplan_bus_pkg.sv | 18 +
 rtl/m68k_bus_responder.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/toaplan_bus_pkg.sv
// Shared definitions for the 68000 bus responder: FSM state encoding,
// data/counter widths and the default read value for unmapped accesses.
package toaplan_bus_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned CNT_W  = 4;

    localparam logic [DATA_W-1:0] UNMAP_DATA_DEFAULT = 16'hFFFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FAST,
        ST_SLOW,
        ST_ACK,
        ST_DRAIN
    } bus_state_e;

endpackage

// File: rtl/m68k_bus_responder.sv
// Slave side of the 68000 bus. Latches the decoder selects on the falling
// edge of the address strobe, times the access (fixed wait for fast sources,
// req/ack handshake for slow ones) and returns a registered DTACK and read
// data to the CPU.
//
// Ports:
//   clk_sys      system clock
//   reset_n      asynchronous active-low reset
//   cpu_as_n     68K address strobe, synchronous to clk_sys
//   cpu_rw       1 = read
//   src_cs       per-source selects from the decoder (one-hot expected)
//   src_dout     per-source read data, source n at [16n+15:16n]
//   src_ack      slow-source completion pulse
//   src_req      slow-source request level, held until ack
//   cpu_din      read data to CPU, valid while cpu_dtack_n is low
//   cpu_dtack_n  data acknowledge to CPU
//   multi_hit    sticky flag: more than one select active at latch time
module m68k_bus_responder
    import toaplan_bus_pkg::*;
#(
    parameter int unsigned        NUM_SRC    = 8,
    parameter logic [NUM_SRC-1:0] SLOW_MASK  = NUM_SRC'(8'h03),
    parameter int unsigned        FAST_WAIT  = 2,
    parameter logic [DATA_W-1:0]  UNMAP_DATA = UNMAP_DATA_DEFAULT
) (
    input  logic                        clk_sys,
    input  logic                        reset_n,
    input  logic                        cpu_as_n,
    input  logic                        cpu_rw,
    input  logic [NUM_SRC-1:0]          src_cs,
    input  logic [DATA_W*NUM_SRC-1:0]   src_dout,
    input  logic [NUM_SRC-1:0]          src_ack,
    output logic [NUM_SRC-1:0]          src_req,
    output logic [DATA_W-1:0]           cpu_din,
    output logic                        cpu_dtack_n,
    output logic                        multi_hit
);

    localparam int unsigned IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    // Lowest-index active select wins.
    function automatic logic [IDX_W-1:0] first_hit(input logic [NUM_SRC-1:0] cs);
        first_hit = '0;
        for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
            if (cs[i]) begin
                first_hit = IDX_W'(i);
            end
        end
    endfunction

    bus_state_e          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                hit_q, hit_d;
    logic                rw_q, rw_d;
    logic [DATA_W-1:0]   din_q, din_d;
    logic [NUM_SRC-1:0]  req_q, req_d;
    logic                dtack_n_q, dtack_n_d;
    logic                multi_q, multi_d;
    logic                pend_q, pend_d;
    logic                as_q;

    logic                as_fall_c;
    logic                start_c;
    logic [IDX_W-1:0]    new_idx_c;
    logic                ack_sel_c;
    logic [DATA_W-1:0]   rd_data_c;

    // as_q resets to "low" so a strobe already low at reset release is not a fall.
    assign as_fall_c = as_q & ~cpu_as_n;
    assign start_c   = (as_fall_c | pend_q) & ~cpu_as_n;
    assign new_idx_c = first_hit(src_cs);
    assign ack_sel_c = src_ack[idx_q];
    assign rd_data_c = src_dout[{idx_q, 4'b0000} +: DATA_W];

    // State and datapath registers.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            hit_q     <= 1'b0;
            rw_q      <= 1'b0;
            din_q     <= '0;
            req_q     <= '0;
            dtack_n_q <= 1'b1;
            multi_q   <= 1'b0;
            pend_q    <= 1'b0;
            as_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            hit_q     <= hit_d;
            rw_q      <= rw_d;
            din_q     <= din_d;
            req_q     <= req_d;
            dtack_n_q <= dtack_n_d;
            multi_q   <= multi_d;
            pend_q    <= pend_d;
            as_q      <= cpu_as_n;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        hit_d     = hit_q;
        rw_d      = rw_q;
        din_d     = din_q;
        req_d     = req_q;
        dtack_n_d = 1'b1;
        multi_d   = multi_q;
        pend_d    = pend_q;

        unique case (state_q)
            ST_IDLE: begin
                pend_d = 1'b0;
                if (start_c) begin
                    idx_d = new_idx_c;
                    hit_d = |src_cs;
                    rw_d  = cpu_rw;
                    if (|(src_cs & (src_cs - NUM_SRC'(1)))) begin
                        multi_d = 1'b1;
                    end
                    if ((|src_cs) && SLOW_MASK[new_idx_c]) begin
                        state_d = ST_SLOW;
                        req_d   = NUM_SRC'(1) << new_idx_c;
                    end else begin
                        state_d = ST_FAST;
                        cnt_d   = CNT_W'(FAST_WAIT - 1);
                    end
                end
            end

            ST_FAST: begin
                if (cpu_as_n) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == '0) begin
                    state_d   = ST_ACK;
                    dtack_n_d = 1'b0;
                    if (rw_q) begin
                        din_d = hit_q ? rd_data_c : UNMAP_DATA;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            ST_SLOW: begin
                if (ack_sel_c) begin
                    req_d = '0;
                    // Ack coinciding with strobe release completes silently.
                    if (cpu_as_n) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d   = ST_ACK;
                        dtack_n_d = 1'b0;
                        if (rw_q) begin
                            din_d = rd_data_c;
                        end
                    end
                end else if (cpu_as_n) begin
                    state_d = ST_DRAIN;
                end
            end

            ST_DRAIN: begin
                // Remember a new strobe fall; forget it if the strobe rises again.
                pend_d = (pend_q & ~cpu_as_n) | as_fall_c;
                if (ack_sel_c) begin
                    req_d   = '0;
                    state_d = ST_IDLE;
                end
            end

            ST_ACK: begin
                if (cpu_as_n) begin
                    state_d = ST_IDLE;
                end else begin
                    dtack_n_d = 1'b0;
                end
            end

            default: begin
                state_d = ST_IDLE;
                req_d   = '0;
            end
        endcase
    end

    assign src_req     = req_q;
    assign cpu_din     = din_q;
    assign cpu_dtack_n = dtack_n_q;
    assign multi_hit   = multi_q;

endmodule
